// File: rtl/spinner_pkg.sv
// spinner_pkg: shared types, limits and saturating add for the spinner step scheduler
package spinner_pkg;
  typedef enum logic {IDLE, RUN} spin_state_t;
  typedef logic signed [11:0] step_budget_t;
  localparam step_budget_t BUDGET_MAX = step_budget_t'(2047);
  localparam step_budget_t BUDGET_MIN = step_budget_t'(-2048);
  localparam int ACC_THRESH = 16;
  function automatic step_budget_t sat_add(step_budget_t a, logic signed [10:0] b);
    logic signed [12:0] s;
    s = 13'(a) + 13'(b);
    return s > 13'(BUDGET_MAX) ? BUDGET_MAX : s < 13'(BUDGET_MIN) ? BUDGET_MIN : s[11:0];
  endfunction
endpackage

// File: rtl/spinner_quad_enc.sv
// spinner_quad_enc: Gray-coded AB up/down stepper, one bit changes per step
module spinner_quad_enc (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       step,
  input  logic       dir,
  output logic [1:0] ab
);
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) ab <= 2'b11;
    else if (step) ab <= dir ? {ab[0], ~ab[1]} : {~ab[0], ab[1]};
endmodule

// File: rtl/spinner_step_scheduler.sv
// spinner_step_scheduler: merges mouse/joystick motion into a step budget drained as quadrature
// steps; define SPINNER_ACCEL_EN to double large mouse deltas.
module spinner_step_scheduler
  import spinner_pkg::*;
#(
  parameter int STEP_DIV   = 50,
  parameter int JOY_PERIOD = 48000,
  parameter int JOY_SLOW   = 4,
  parameter int JOY_FAST   = 9
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              mouse_strobe,
  input  logic signed [8:0] mouse_dx,
  input  logic              joy_right,
  input  logic              joy_left,
  input  logic              joy_fast,
  output logic [1:0]        spinner,
  output logic              busy,
  output logic signed [11:0] budget
);
  localparam int SW = $clog2(STEP_DIV + 1);
  localparam int JW = $clog2(JOY_PERIOD);
  spin_state_t state;
  logic [SW-1:0] step_cnt;
  logic [JW-1:0] joy_cnt;
  logic strobe_q, primed, mouse_evt, step, joy_one, joy_load, opp;
  logic signed [10:0] dx_eff;
  step_budget_t jmag, b_step, b_joy, b_next;
  always_comb begin
    mouse_evt = primed && (mouse_strobe != strobe_q);
`ifdef SPINNER_ACCEL_EN
    dx_eff = (mouse_dx > 9'(ACC_THRESH) || mouse_dx < -9'(ACC_THRESH)) ? 11'(mouse_dx) <<< 1 : 11'(mouse_dx);
`else
    dx_eff = 11'(mouse_dx);
`endif
    step = (state == RUN) && (step_cnt == SW'(STEP_DIV - 1));
    joy_one = joy_right ^ joy_left;
    joy_load = joy_one && (joy_cnt == JW'(JOY_PERIOD - 1));
    jmag = step_budget_t'(joy_fast ? JOY_FAST : JOY_SLOW);
    b_step = step ? (budget[11] ? budget + 12'sd1 : budget - 12'sd1) : budget;
    // Joystick reload lands first; the mouse rule then sees the reloaded value
    b_joy = joy_load ? (joy_left ? -jmag : jmag) : b_step;
    opp = (b_joy[11] != dx_eff[10]) && (b_joy != '0) && (dx_eff != '0);
    b_next = !mouse_evt ? b_joy : opp ? step_budget_t'(dx_eff) : sat_add(b_joy, dx_eff);
  end
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      state <= IDLE;
      step_cnt <= '0;
      joy_cnt <= '0;
      budget <= '0;
      busy <= 1'b0;
      strobe_q <= 1'b0;
      primed <= 1'b0;
    end else begin
      strobe_q <= mouse_strobe;
      primed <= 1'b1;
      budget <= b_next;
      busy <= b_next != '0;
      joy_cnt <= (!joy_one || joy_load) ? '0 : joy_cnt + 1'b1;
      // The idle cycle that sees a nonzero budget counts as step slot 0
      if (state == IDLE) begin
        state <= budget != '0 ? RUN : IDLE;
        step_cnt <= budget != '0 ? SW'(1) : '0;
      end else begin
        state <= b_next == '0 ? IDLE : RUN;
        step_cnt <= (b_next == '0 || step) ? '0 : step_cnt + 1'b1;
      end
    end
  spinner_quad_enc enc (
    .clk_sys(clk_sys),
    .reset(reset),
    .step(step),
    .dir(budget[11]),
    .ab(spinner)
  );
endmodule

// File: tb/tb_spinner_step_scheduler.sv
// tb_spinner_step_scheduler: directed checks of budget arithmetic, step cadence and joystick reloads
module tb_spinner_step_scheduler;
  localparam int SD = 8;
  localparam int JP = 100;
  logic clk_sys = 1'b0;
  logic reset = 1'b1;
  logic mouse_strobe = 1'b0;
  logic signed [8:0] mouse_dx = '0;
  logic joy_right = 1'b0;
  logic joy_left = 1'b0;
  logic joy_fast = 1'b0;
  logic [1:0] spinner;
  logic busy;
  logic signed [11:0] budget;
  int total = 0;
  int bad = 0;
  always #5 clk_sys = ~clk_sys;
  spinner_step_scheduler #(.STEP_DIV(SD), .JOY_PERIOD(JP), .JOY_SLOW(4), .JOY_FAST(9)) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .mouse_strobe(mouse_strobe),
    .mouse_dx(mouse_dx),
    .joy_right(joy_right),
    .joy_left(joy_left),
    .joy_fast(joy_fast),
    .spinner(spinner),
    .busy(busy),
    .budget(budget)
  );
  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask
  task automatic strobe(input logic signed [8:0] dx);
    mouse_dx = dx;
    mouse_strobe = ~mouse_strobe;
  endtask
  initial begin
    cyc(2);
    reset = 1'b0;
    cyc(10 * SD);
    chk("idle_spinner", spinner, 3);
    chk("idle_busy", busy, 0);
    chk("idle_budget", budget, 0);
    strobe(3);
    cyc(1);
    chk("p3_budget", budget, 3);
    chk("p3_busy", busy, 1);
    chk("p3_spin_hold", spinner, 3);
    cyc(SD - 1);
    chk("p3_latency", spinner, 3);
    cyc(1);
    chk("p3_step1", spinner, 1);
    chk("p3_budget1", budget, 2);
    cyc(SD);
    chk("p3_step2", spinner, 0);
    chk("p3_budget2", budget, 1);
    cyc(SD);
    chk("p3_step3", spinner, 2);
    chk("p3_budget3", budget, 0);
    chk("p3_busy_drop", busy, 0);
    cyc(2 * SD);
    chk("p3_no_extra", spinner, 2);
    for (int i = 0; i < 10; i++) begin
      strobe(255);
      cyc(1);
    end
    chk("sat_budget", budget, 2047);
    chk("sat_spinner", spinner, 3);
    strobe(-5);
    cyc(1);
    chk("rev_budget", budget, -5);
    cyc(6);
    chk("rev_step", spinner, 2);
    chk("rev_budget1", budget, -4);
    cyc(4 * SD);
    chk("rev_drain", budget, 0);
    chk("rev_drain_busy", busy, 0);
    chk("rev_drain_spin", spinner, 2);
    joy_right = 1'b1;
    joy_fast = 1'b1;
    cyc(JP - 1);
    chk("joy_early", budget, 0);
    cyc(1);
    chk("joy_load1", budget, 9);
    cyc(JP);
    chk("joy_load2", budget, 9);
    cyc(JP);
    chk("joy_load3", budget, 9);
    joy_left = 1'b1;
    cyc(150);
    chk("joy_both", budget, 0);
    chk("joy_both_busy", busy, 0);
    joy_left = 1'b0;
    cyc(JP - 1);
    chk("joy_restart_early", budget, 0);
    cyc(1);
    chk("joy_restart", budget, 9);
    joy_right = 1'b0;
    joy_fast = 1'b0;
    cyc(80);
    chk("joy_drain", budget, 0);
    joy_left = 1'b1;
    cyc(JP - 1);
    strobe(-2);
    cyc(1);
    chk("merge_budget", budget, -6);
    chk("merge_busy", busy, 1);
    joy_left = 1'b0;
    cyc(1);
    chk("merge_single", budget, -6);
    strobe(100);
    cyc(1);
    chk("run_budget", budget, 100);
    cyc(20);
    chk("run_cadence", budget, 98);
    #2;
    reset = 1'b1;
    mouse_strobe = ~mouse_strobe;
    #1;
    chk("rst_spinner", spinner, 3);
    chk("rst_budget", budget, 0);
    chk("rst_busy", busy, 0);
    cyc(2);
    reset = 1'b0;
    cyc(2 * SD);
    chk("rst_edge_lost", budget, 0);
    chk("rst_spin_hold", spinner, 3);
    strobe(20);
    cyc(1);
`ifdef SPINNER_ACCEL_EN
    chk("acc_big", budget, 40);
`else
    chk("acc_big", budget, 20);
`endif
    strobe(-10);
    cyc(1);
    chk("acc_small_rev", budget, -10);
    strobe(-20);
    cyc(1);
`ifdef SPINNER_ACCEL_EN
    chk("acc_neg_add", budget, -50);
`else
    chk("acc_neg_add", budget, -30);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
